// File: rtl/kl_wmask_split_pkg.sv
// Shared KLink constants, FSM state type and size-to-span helper for kl_wmask_split.
package kl_wmask_split_pkg;

   localparam int unsigned KL_ADDR_W = 32;
   localparam int unsigned KL_DATA_W = 64;
   localparam int unsigned KL_ID_W   = 5;
   localparam int unsigned KL_MASK_W = 8;

   localparam logic [2:0] KL_SIZE_1B = 3'd0;
   localparam logic [2:0] KL_SIZE_2B = 3'd1;
   localparam logic [2:0] KL_SIZE_4B = 3'd2;
   localparam logic [2:0] KL_SIZE_8B = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   // Byte-lane footprint of an aligned access of the given size, anchored at lane 0.
   function automatic logic [KL_MASK_W-1:0] size_span(input logic [2:0] size);
      case (size)
         KL_SIZE_1B: return 8'h01;
         KL_SIZE_2B: return 8'h03;
         KL_SIZE_4B: return 8'h0F;
         default:    return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/kl_wmask_split_if.sv
// KLink request/response bundle; master drives requests, slave drives responses.
interface kl_wmask_split_if;
   import kl_wmask_split_pkg::*;

   logic [KL_ADDR_W-1:0] req_addr;
   logic                 req_wen;
   logic [KL_DATA_W-1:0] req_wdata;
   logic [KL_MASK_W-1:0] req_wmask;
   logic [2:0]           req_size;
   logic [KL_ID_W-1:0]   req_srcid;
   logic                 req_valid;
   logic                 req_ready;

   logic [KL_DATA_W-1:0] resp_rdata;
   logic                 resp_ren;
   logic [2:0]           resp_size;
   logic [KL_ID_W-1:0]   resp_dstid;
   logic                 resp_valid;
   logic                 resp_ready;

   modport master (
      output req_addr, req_wen, req_wdata, req_wmask, req_size, req_srcid, req_valid,
      input  req_ready,
      input  resp_rdata, resp_ren, resp_size, resp_dstid, resp_valid,
      output resp_ready
   );

   modport slave (
      input  req_addr, req_wen, req_wdata, req_wmask, req_size, req_srcid, req_valid,
      output req_ready,
      output resp_rdata, resp_ren, resp_size, resp_dstid, resp_valid,
      input  resp_ready
   );

endinterface

// File: rtl/kl_wmask_split_chunk_sel.sv
// Picks the largest naturally aligned chunk starting at the lowest pending byte of rem_i.
module kl_chunk_sel
   import kl_wmask_split_pkg::*;
(
   input  logic [KL_MASK_W-1:0] rem_i,
   output logic [2:0]           off_o,
   output logic [2:0]           size_o,
   output logic [KL_MASK_W-1:0] clr_mask_o
);

   logic                 found;
   logic [KL_MASK_W-1:0] run;

   always_comb begin
      off_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < KL_MASK_W; i++) begin
         if (!found && rem_i[i]) begin
            off_o = i[2:0];
            found = 1'b1;
         end
      end

      // run[0] is the lowest pending byte; alignment of off_o bounds the chunk size
      run = rem_i >> off_o;
      if (off_o == 3'd0 && run == 8'hFF) begin
         size_o = KL_SIZE_8B;
      end else if (off_o[1:0] == 2'b00 && (&run[3:0])) begin
         size_o = KL_SIZE_4B;
      end else if (!off_o[0] && (&run[1:0])) begin
         size_o = KL_SIZE_2B;
      end else begin
         size_o = KL_SIZE_1B;
      end

      clr_mask_o = size_span(size_o) << off_o;
   end

endmodule

// File: rtl/kl_wmask_split.sv
// Splits masked KLink writes into aligned mask-less pieces and merges their acks.
// Optional KL_SPLIT_RESP_BYPASS_EN: forward the final downstream response combinationally.
module kl_wmask_split
   import kl_wmask_split_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   kl_wmask_split_if.slave  a,
   kl_wmask_split_if.master b
);

   state_e               state_q, state_d;
   logic [KL_ADDR_W-1:0] addr_q, addr_d;
   logic                 wen_q, wen_d;
   logic [KL_DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]           size_q, size_d;
   logic [KL_ID_W-1:0]   srcid_q, srcid_d;
   logic [KL_MASK_W-1:0] rem_q, rem_d;
   logic [2:0]           issued_q, issued_d;
   logic [2:0]           acked_q, acked_d;
   logic [KL_DATA_W-1:0] rdata_q, rdata_d;

   logic [2:0]           sel_off;
   logic [2:0]           sel_size;
   logic [KL_MASK_W-1:0] sel_clr;

   kl_chunk_sel u_chunk_sel (
      .rem_i      (rem_q),
      .off_o      (sel_off),
      .size_o     (sel_size),
      .clr_mask_o (sel_clr)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      srcid_d  = srcid_q;
      rem_d    = rem_q;
      issued_d = issued_q;
      acked_d  = acked_q;
      rdata_d  = rdata_q;

      a.req_ready  = 1'b0;
      a.resp_valid = 1'b0;
      a.resp_rdata = rdata_q;
      a.resp_ren   = ~wen_q;
      a.resp_size  = size_q;
      a.resp_dstid = srcid_q;

      b.req_valid  = 1'b0;
      b.req_addr   = wen_q ? {addr_q[KL_ADDR_W-1:3], sel_off} : addr_q;
      b.req_wen    = wen_q;
      b.req_wdata  = wdata_q;
      b.req_wmask  = '0;
      b.req_size   = wen_q ? sel_size : size_q;
      b.req_srcid  = srcid_q;
      b.resp_ready = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            a.req_ready = ~rst;
            if (a.req_valid && !rst) begin
               addr_d  = a.req_addr;
               wen_d   = a.req_wen;
               wdata_d = a.req_wdata;
               size_d  = a.req_size;
               srcid_d = a.req_srcid;
               if (a.req_wen) begin
                  rem_d   = a.req_wmask;
                  state_d = (a.req_wmask == '0) ? ST_RESP : ST_ISSUE;
               end else begin
                  rem_d   = '0;
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            b.req_valid  = 1'b1;
            b.resp_ready = 1'b1;
            if (b.resp_valid) begin
               acked_d = acked_q + 3'd1;
               if (!wen_q) rdata_d = b.resp_rdata;
            end
            if (b.req_ready) begin
               issued_d = issued_q + 3'd1;
               rem_d    = wen_q ? (rem_q & ~sel_clr) : '0;
               // all responses may already be in; skip WAIT to keep the ack one cycle behind
               if (rem_d == '0) state_d = (acked_d == issued_d) ? ST_RESP : ST_WAIT;
            end
         end

         ST_WAIT: begin
`ifdef KL_SPLIT_RESP_BYPASS_EN
            if (acked_q + 3'd1 == issued_q) begin
               b.resp_ready = a.resp_ready;
               a.resp_valid = b.resp_valid;
               a.resp_rdata = b.resp_rdata;
               if (b.resp_valid && a.resp_ready) begin
                  state_d  = ST_IDLE;
                  issued_d = '0;
                  acked_d  = '0;
               end
            end else begin
               b.resp_ready = 1'b1;
               if (b.resp_valid) begin
                  acked_d = acked_q + 3'd1;
                  if (!wen_q) rdata_d = b.resp_rdata;
               end
            end
`else
            b.resp_ready = 1'b1;
            if (b.resp_valid) begin
               acked_d = acked_q + 3'd1;
               if (!wen_q) rdata_d = b.resp_rdata;
               if (acked_d == issued_q) state_d = ST_RESP;
            end
`endif
         end

         ST_RESP: begin
            a.resp_valid = 1'b1;
            if (a.resp_ready) begin
               state_d  = ST_IDLE;
               issued_d = '0;
               acked_d  = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         size_q   <= '0;
         srcid_q  <= '0;
         rem_q    <= '0;
         issued_q <= '0;
         acked_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         srcid_q  <= srcid_d;
         rem_q    <= rem_d;
         issued_q <= issued_d;
         acked_q  <= acked_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule
